uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 434, giving clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, giving transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port tx_data, input, 8 bits: byte to transmit.
REQ-006 SHALL provide port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 SHALL provide port tx_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-008 SHALL provide port txd, output, 1 bit: serial line, idle high, registered.
REQ-009 SHALL provide port busy, output, 1 bit: FIFO non-empty or frame in progress.
REQ-010 SHALL provide port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-011 SHALL accept a byte into the FIFO on a rising edge where tx_valid and tx_ready are both 1; otherwise the FIFO is unchanged by the write side.
REQ-012 SHALL drive tx_ready = 1 exactly when fifo_count < FIFO_DEPTH, with no pop-bypass: a full FIFO refuses a write even in a popping cycle.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-024.
REQ-014 SHALL pop the FIFO head into an 8-bit shift register, move to START and drive txd = 0 on the first edge where the state is IDLE and fifo_count > 0.
- txd falls one clock after the accepting edge when the FIFO was empty and the FSM was idle.
REQ-015 SHALL hold every bit (start, each data bit, parity, stop) on txd for exactly BAUD_DIV clock cycles, timed by a baud counter cleared on each bit boundary.
REQ-016 SHALL send the data bits LSB first (D0..D7) in DATA, using a 3-bit bit index that wraps 7 to 0 on leaving DATA.
REQ-017 SHALL send one stop bit with txd = 1.
REQ-018 SHALL, at the end of STOP, pop the next byte and enter START on the same edge if the FIFO is non-empty, with zero idle cycles between frames; otherwise it enters IDLE.
REQ-019 SHALL apply simultaneous push and pop in the same cycle, leaving fifo_count unchanged, with the pushed byte queued behind the existing entries.
REQ-020 SHALL ignore changes to tx_data or tx_valid while a frame is in progress; the shifted byte is the latched copy.
REQ-021 SHALL drive busy = 1 when the state is not IDLE or fifo_count is nonzero.

Reset
REQ-022 SHALL, while reset is high and independent of clk, force state = IDLE, txd = 1, the FIFO empty (fifo_count = 0, pointers 0), the baud counter and bit index to 0, tx_ready = 1 and busy = 0.
REQ-023 SHALL abort a frame when reset is asserted mid-frame, with no partial completion; the first frame after release starts cleanly with a full-length start bit.

Configuration
REQ-024 SHALL, when macro UART_TX_PARITY_EN is defined, insert PARITY between DATA and STOP carrying even parity (XOR of D7..D0), giving an 11-bit frame of 11*BAUD_DIV cycles.
REQ-025 SHALL, when UART_TX_PARITY_EN is undefined, contain no parity logic or state and go from DATA directly to STOP, giving a 10-bit frame of 10*BAUD_DIV cycles.

Verification (BAUD_DIV = 4, FIFO_DEPTH = 4)
REQ-026 SHALL be verified by: reset high -> txd = 1, tx_ready = 1, busy = 0, fifo_count = 0; release with tx_valid = 0 for 50 cycles -> outputs unchanged.
REQ-027 SHALL be verified by: one write of 0x55 -> txd low 1 clock later, then 0,1,0,1,0,1,0,1,0 (start, D0..D7) then stop 1, each bit 4 cycles; busy falls 40 cycles after the start edge (44 with parity).
REQ-028 SHALL be verified by: tx_valid held with 0x01..0x06 -> first byte popped, tx_ready low once 4 are queued, all six frames back-to-back with no idle gap, decoded in order.
REQ-029 SHALL be verified with UART_TX_PARITY_EN defined by: 0x07 -> parity bit 1; 0x03 -> parity bit 0; each frame 44 cycles.
REQ-030 SHALL be verified by: 0xA5 and 0x3C queued, reset pulsed during D3 of 0xA5 -> txd = 1 within the same cycle, fifo_count = 0; a write of 0x81 after release -> one clean 0x81 frame only.
REQ-031 SHALL be verified by: full FIFO with a push attempted on the popping edge -> push refused, fifo_count stays 3 after the pop, no byte lost or duplicated.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO in front of the shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_tx #(
   parameter int BAUD_DIV   = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    head;
   logic          push;
   logic          pop;

   state_t        state;
   state_t        state_nxt;
   logic [15:0]   baud_cnt;
   logic [15:0]   baud_cnt_nxt;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_nxt;
   logic          txd_nxt;
   logic [7:0]    shift;
   logic          load;
   logic          shift_en;
   logic          bit_end;
`ifdef UART_TX_PARITY_EN
   logic          par;
`endif

   // A full FIFO refuses writes even when the shifter pops in the same cycle.
   assign tx_ready   = (count < DEPTH_C);
   assign push       = tx_valid && tx_ready;
   assign head       = mem[rd_ptr];
   assign fifo_count = count;
   assign busy       = (state != IDLE) || (count != '0);
   assign bit_end    = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         txd      <= txd_nxt;
      end
   end

   // The shifter holds the latched byte; later tx_data changes never reach it.
   always_ff @(posedge clk) begin
      if (load) begin
         shift <= head;
`ifdef UART_TX_PARITY_EN
         par   <= ^head;
`endif
      end else if (shift_en) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt + 16'd1;
      bit_idx_nxt  = bit_idx;
      txd_nxt      = txd;
      pop          = 1'b0;
      load         = 1'b0;
      shift_en     = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_nxt = '0;
            txd_nxt      = 1'b1;
            if (count != '0) begin
               pop       = 1'b1;
               load      = 1'b1;
               state_nxt = START;
               txd_nxt   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = DATA;
               txd_nxt      = shift[0];
               shift_en     = 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               if (bit_idx == 3'd7) begin
                  bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt   = PARITY;
                  txd_nxt     = par;
`else
                  state_nxt   = STOP;
                  txd_nxt     = 1'b1;
`endif
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
                  txd_nxt     = shift[0];
                  shift_en    = 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = STOP;
               txd_nxt      = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               // Chain straight into the next start bit when more data is queued.
               if (count != '0) begin
                  pop       = 1'b1;
                  load      = 1'b1;
                  state_nxt = START;
                  txd_nxt   = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  txd_nxt   = 1'b1;
               end
            end
         end
         default: begin
            state_nxt    = IDLE;
            baud_cnt_nxt = '0;
            bit_idx_nxt  = '0;
            txd_nxt      = 1'b1;
         end
      endcase
   end

endmodule
